// File: rtl/centroid_finder.sv
// centroid_finder
//   Tracks the camera raster (col/row) from the decoder sync bits, accumulates
//   the column sum, row sum and count of pixels at or above THRESH, and at each
//   field start divides both sums by the count with a serial restoring divider.
//   The resulting centre (cx, cy) is held until the next result.
//
// Ports
//   vclk   : video clock, sole clock
//   reset  : asynchronous active-low reset
//   fvh    : {field, vsync, hsync} from the decoder
//   dv     : pixel data valid
//   pixel  : 8-bit pixel value
//   cx/cy  : centroid column/row, clamped to X_MAX/Y_MAX
//   count  : qualifying pixels in the last completed field
//   found  : last result had count >= MIN_COUNT
//   valid  : one-cycle pulse when cx/cy/count/found update
//   busy   : divider running
module centroid_finder #(
    parameter logic [7:0]  THRESH    = 8'hFF,
    parameter logic [9:0]  COL_START = 10'd0,
    parameter logic [9:0]  ROW_START = 10'd0,
    parameter logic [19:0] MIN_COUNT = 20'd16,
    parameter logic [10:0] X_MAX     = 11'd524,
    parameter logic [9:0]  Y_MAX     = 10'd524
) (
    input  logic        vclk,
    input  logic        reset,
    input  logic [2:0]  fvh,
    input  logic        dv,
    input  logic [7:0]  pixel,
    output logic [10:0] cx,
    output logic [9:0]  cy,
    output logic [19:0] count,
    output logic        found,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor when it fits. Returns {rem_next, qbit}.
    // The true difference is below the divisor, so a 20-bit subtract is exact.
    function automatic logic [20:0] div_step(input logic [19:0] rem,
                                             input logic        nb,
                                             input logic [19:0] dvs);
        logic [20:0] sh;
        logic [19:0] diff;
        sh   = {rem, nb};
        diff = sh[19:0] - dvs;
        if ((dvs != 20'd0) && (sh >= {1'b0, dvs}))
            return {diff, 1'b1};
        else
            return {sh[19:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Raster counters, qualification and accumulators
    // ------------------------------------------------------------------
    // col is one bit wider than its start value so it can park at 1024
    // on overlong lines instead of wrapping back into the image.
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        fvh2_q, fvh2_d;
    logic [29:0] sum_x_q, sum_x_d;
    logic [29:0] sum_y_q, sum_y_d;
    logic [19:0] cnt_q, cnt_d;
    logic        q_pix;
    logic        frame_edge;

    assign frame_edge = fvh[2] & ~fvh2_q;
    // Blanking of any kind excludes the pixel; col/row are the pre-update values.
    assign q_pix = ~fvh[2] & ~fvh[1] & ~fvh[0] & dv & (pixel >= THRESH);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        fvh2_d = fvh[2];
        if (!fvh[2]) begin
            if (fvh[0])
                col_d = {1'b0, COL_START};
            else if (!fvh[1] && dv && (col_q < 11'd1024))
                col_d = col_q + 11'd1;

            if (fvh[1])
                row_d = ROW_START;
            else if (fvh[0] && (row_q < 10'd768))
                row_d = row_q + 10'd2;
        end
    end

    always_comb begin
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        if (frame_edge) begin
            // Totals move into the divider this cycle; start the new field clean.
            sum_x_d = 30'd0;
            sum_y_d = 30'd0;
            cnt_d   = 20'd0;
        end else if (q_pix && (cnt_q != 20'hFFFFF)) begin
            // Sums freeze together with a saturated count so the ratio stays sane.
            sum_x_d = sum_x_q + {19'd0, col_q};
            sum_y_d = sum_y_q + {20'd0, row_q};
            cnt_d   = cnt_q + 20'd1;
        end
    end

    always_ff @(posedge vclk or negedge reset) begin
        if (!reset) begin
            col_q   <= {1'b0, COL_START};
            row_q   <= ROW_START;
            fvh2_q  <= 1'b0;
            sum_x_q <= 30'd0;
            sum_y_q <= 30'd0;
            cnt_q   <= 20'd0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            fvh2_q  <= fvh2_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Serial divider datapath (both quotients share the divisor)
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [4:0]  bit_idx_q;
    logic [29:0] dvd_x_q, dvd_y_q;   // dividends, consumed MSB first
    logic [19:0] rem_x_q, rem_y_q;
    logic [28:0] quo_x_q, quo_y_q;   // quotient bits so far; last bit comes from step
    logic [19:0] dvs_q;              // latched count, also the reported count
    logic [20:0] step_x, step_y;
    logic [29:0] quo_x_nx, quo_y_nx;
    logic [10:0] cx_nx;
    logic [9:0]  cy_nx;
    logic [10:0] cx_q;
    logic [9:0]  cy_q;
    logic [19:0] count_q;
    logic        found_q, valid_q, busy_q;

    always_comb begin
        step_x   = div_step(rem_x_q, dvd_x_q[29], dvs_q);
        step_y   = div_step(rem_y_q, dvd_y_q[29], dvs_q);
        quo_x_nx = {quo_x_q, step_x[0]};
        quo_y_nx = {quo_y_q, step_y[0]};
        // Clamp on the full-width quotient before narrowing.
        cx_nx    = (quo_x_nx > {19'd0, X_MAX}) ? X_MAX : quo_x_nx[10:0];
        cy_nx    = (quo_y_nx > {20'd0, Y_MAX}) ? Y_MAX : quo_y_nx[9:0];
    end

    // Results are registered on the edge leaving the last DIV cycle, so
    // valid is high during DONE: 31 cycles after the frame_edge cycle.
    always_ff @(posedge vclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_idx_q <= 5'd0;
            dvd_x_q   <= 30'd0;
            dvd_y_q   <= 30'd0;
            rem_x_q   <= 20'd0;
            rem_y_q   <= 20'd0;
            quo_x_q   <= 29'd0;
            quo_y_q   <= 29'd0;
            dvs_q     <= 20'd0;
            cx_q      <= 11'd0;
            cy_q      <= 10'd0;
            count_q   <= 20'd0;
            found_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (frame_edge) begin
                // Any state: latch new operands and (re)start. A division in
                // flight is dropped; a DONE cycle has already published.
                state_q   <= DIV;
                bit_idx_q <= 5'd29;
                dvd_x_q   <= sum_x_q;
                dvd_y_q   <= sum_y_q;
                dvs_q     <= cnt_q;
                rem_x_q   <= 20'd0;
                rem_y_q   <= 20'd0;
                quo_x_q   <= 29'd0;
                quo_y_q   <= 29'd0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    DIV: begin
                        rem_x_q <= step_x[20:1];
                        rem_y_q <= step_y[20:1];
                        quo_x_q <= quo_x_nx[28:0];
                        quo_y_q <= quo_y_nx[28:0];
                        dvd_x_q <= {dvd_x_q[28:0], 1'b0};
                        dvd_y_q <= {dvd_y_q[28:0], 1'b0};
                        if (bit_idx_q == 5'd0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            count_q <= dvs_q;
                            found_q <= (dvs_q >= MIN_COUNT);
                            if (dvs_q >= MIN_COUNT) begin
                                cx_q <= cx_nx;
                                cy_q <= cy_nx;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q - 5'd1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cx    = cx_q;
    assign cy    = cy_q;
    assign count = count_q;
    assign found = found_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_centroid_finder.sv
// Directed bench for centroid_finder: drives whole fields with known pixel
// placements, keeps a field-level model (sums/count from the intended pixel
// coordinates, result due 31 cycles after each field start) and compares every
// cycle, plus literal expectations for the named scenarios.
module tb_centroid_finder;

    logic        vclk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  fvh = 3'b000;
    logic        dv = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [19:0] count;
    logic        found, valid, busy;

    centroid_finder dut (
        .vclk(vclk), .reset(reset), .fvh(fvh), .dv(dv), .pixel(pixel),
        .cx(cx), .cy(cy), .count(count), .found(found), .valid(valid), .busy(busy)
    );

    always #5 vclk = ~vclk;

    int cyc = 0;
    always @(posedge vclk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Field accumulation from the driver's intended coordinates
    longint m_sx = 0, m_sy = 0;
    int     m_n = 0;
    // Pending result
    bit     pend = 0;
    int     due = 0, pend_edge = 0;
    longint p_sx = 0, p_sy = 0;
    int     p_n = 0;
    // Currently published outputs
    int     h_cx = 0, h_cy = 0, h_n = 0;
    bit     h_found = 0;
    bit     prev_f2 = 0;
    int     last_edge = 0;

    always @(negedge vclk) begin
        bit e_valid, e_busy;
        if (!reset) begin
            m_sx = 0; m_sy = 0; m_n = 0; pend = 0;
            h_cx = 0; h_cy = 0; h_n = 0; h_found = 0; prev_f2 = 0;
            e_valid = 0; e_busy = 0;
        end else begin
            e_valid = pend && (cyc == due);
            e_busy  = pend && (cyc > pend_edge) && (cyc < due);
            if (e_valid) begin
                h_n = p_n;
                h_found = (p_n >= 16);
                if (h_found) begin
                    h_cx = (p_sx / p_n > 524) ? 524 : int'(p_sx / p_n);
                    h_cy = (p_sy / p_n > 524) ? 524 : int'(p_sy / p_n);
                end
                pend = 0;
            end
        end
        vectors++;
        if (valid !== e_valid || busy !== e_busy || cx !== h_cx[10:0] || cy !== h_cy[9:0] ||
            count !== h_n[19:0] || found !== h_found) begin
            miscompares++;
            $display("FAIL cycle %0d: got v=%b b=%b cx=%0d cy=%0d n=%0d f=%b, want v=%b b=%b cx=%0d cy=%0d n=%0d f=%b",
                     cyc, valid, busy, cx, cy, count, found, e_valid, e_busy, h_cx, h_cy, h_n, h_found);
        end
        if (reset) begin
            if (fvh[2] && !prev_f2) begin
                // New field start supersedes any unfinished result
                pend = 1; pend_edge = cyc; due = cyc + 31; last_edge = cyc;
                p_sx = m_sx; p_sy = m_sy; p_n = m_n;
                m_sx = 0; m_sy = 0; m_n = 0;
            end
            prev_f2 = fvh[2];
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input logic [2:0] f, input logic d, input logic [7:0] p);
        @(posedge vclk); #1;
        fvh = f; dv = d; pixel = p;
    endtask

    task automatic pix(input int row, input int col, input logic [7:0] p);
        tick(3'b000, 1'b1, p);
        if (p >= 8'hFF) begin
            m_sx += col; m_sy += row; m_n++;
        end
    endtask

    task automatic field_start();
        tick(3'b001, 1'b0, 8'h00);   // hsync: col to start
        tick(3'b010, 1'b0, 8'h00);   // vsync: row to start
    endtask

    task automatic edge_cycle();
        tick(3'b100, 1'b0, 8'h00);
    endtask

    function automatic int nlines(input int k);
        case (k)
            1: return 110;
            2: return 70;
            3: return 304;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int width(input int k, input int l);
        case (k)
            1: return (l >= 100 && l <= 109) ? 110 : 0;
            2: return (l >= 50) ? 52 : 0;
            3: return (l >= 300) ? 604 : 0;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] pat(input int k, input int c);
        case (k)
            1: return (c >= 100) ? 8'hFF : 8'h00;
            2: return (c == 50) ? 8'hFF : (c == 51) ? 8'hFE : 8'h00;
            3: return (c >= 600) ? 8'hFF : 8'h00;
            4: return (c >= 3 && c <= 6) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // Line l is raster row 2*l; pixel c of a line is column c.
    task automatic drive_field(input int k);
        field_start();
        for (int l = 0; l < nlines(k); l++) begin
            for (int c = 0; c < width(k, l); c++) pix(2 * l, c, pat(k, c));
            tick(3'b001, 1'b0, 8'h00);
        end
        edge_cycle();
    endtask

    // Short field ending with a frame edge exactly gap cycles after the last one.
    task automatic quick(input int gap, input int npix);
        field_start();
        for (int c = 0; c < npix; c++) pix(0, c, 8'hFF);
        repeat (gap - 3 - npix) tick(3'b000, 1'b0, 8'h00);
        edge_cycle();
    endtask

    task automatic expect_result(input string nm, input int n, input int x, input int y, input bit f);
        bit seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge vclk);
            if (valid) begin seen = 1; break; end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s: no valid pulse within 40 cycles of the field start", nm);
        end else if ((cyc - last_edge) != 31 || count != n || cx != x || cy != y || found != f) begin
            miscompares++;
            $display("FAIL %s: lat=%0d n=%0d cx=%0d cy=%0d f=%b, want lat=31 n=%0d cx=%0d cy=%0d f=%b",
                     nm, cyc - last_edge, count, cx, cy, found, n, x, y, f);
        end
    endtask

    task automatic expect_no_valid(input string nm, input int ncyc);
        int seen = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge vclk);
            if (valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL %s: %0d valid pulses, want 0", nm, seen);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick(3'b000, 1'b0, 8'h00);
        @(posedge vclk); #1 reset = 1'b1;

        // 10x10 block, cols 100..109, rows 200..218
        drive_field(1);
        expect_result("block", 100, 104, 209, 1'b1);

        // empty field keeps the centre
        drive_field(0);
        expect_result("empty", 0, 104, 209, 1'b0);

        // reset mid-stream: outputs clear immediately
        field_start();
        for (int c = 0; c < 5; c++) pix(0, c, 8'hFF);
        @(posedge vclk); #1 reset = 1'b0; fvh = 3'b000; dv = 1'b0;
        #1;
        vectors++;
        if (cx != 0 || cy != 0 || count != 0 || found != 0 || valid != 0 || busy != 0) begin
            miscompares++;
            $display("FAIL reset_async: cx=%0d cy=%0d n=%0d f=%b v=%b b=%b, want all 0",
                     cx, cy, count, found, valid, busy);
        end
        tick(3'b000, 1'b0, 8'h00);
        @(posedge vclk); #1 reset = 1'b1;

        drive_field(4);
        expect_result("small", 16, 4, 3, 1'b1);

        // reset during DIV: the result is lost
        drive_field(4);
        repeat (10) tick(3'b000, 1'b0, 8'h00);
        @(posedge vclk); #1 reset = 1'b0;
        tick(3'b000, 1'b0, 8'h00);
        @(posedge vclk); #1 reset = 1'b1;
        expect_no_valid("reset_in_div", 40);

        // threshold: FE pixels at column 51 ignored
        drive_field(2);
        expect_result("thresh", 20, 50, 119, 1'b1);

        // clamp
        drive_field(3);
        expect_result("clamp", 16, 524, 524, 1'b1);

        // back-to-back: second field start 10 cycles after the first
        drive_field(4);
        quick(10, 6);
        expect_result("back_to_back", 6, 524, 524, 1'b0);

        // field start landing in the DONE cycle
        drive_field(4);
        quick(31, 20);
        @(negedge vclk);
        vectors++;
        if (!(valid && count == 16 && cx == 4 && cy == 3 && found)) begin
            miscompares++;
            $display("FAIL done_edge_first: v=%b n=%0d cx=%0d cy=%0d f=%b, want v=1 n=16 cx=4 cy=3 f=1",
                     valid, count, cx, cy, found);
        end
        expect_result("done_edge_second", 20, 9, 0, 1'b1);

        repeat (5) tick(3'b000, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/centroid_finder.md
Name: centroid_finder

Overview:
- Upstream stage of the bounding-box tracker; computes the centroid of thresholded "white" pixels in each field.
- Watches the same camera stream (fvh, dv, pixel) and regenerates the col/row raster count.
- Accumulates the column sum, row sum and pixel count, then divides serially at each field start.
- Presents cx/cy, which the tracker holds constant as its box centre for the following field.

Parameters:
THRESH, 8'hFF, pixel qualifies when pixel >= THRESH
COL_START, 10'd0, col value loaded on hsync
ROW_START, 10'd0, row value loaded on vsync
MIN_COUNT, 20'd16, minimum qualifying pixels for a valid centroid
X_MAX, 11'd524, cx clamp ceiling
Y_MAX, 10'd524, cy clamp ceiling

Ports:
vclk  input  1  video clock from camera, sole clock
reset  input  1  asynchronous, active-low reset
fvh  input  3  {field, vsync, hsync} from decoder
dv  input  1  pixel data valid
pixel  input  8  black/white pixel
cx  output  11  centroid column
cy  output  10  centroid row
count  output  20  qualifying pixels in last completed field
found  output  1  last result had count >= MIN_COUNT
valid  output  1  one-cycle pulse: cx/cy/count/found updated
busy  output  1  divider running

Behaviour:
- Reset (reset==0, asynchronous): cx=0, cy=0, count=0, found=0, valid=0, busy=0. col=COL_START, row=ROW_START. Accumulators=0. FSM=IDLE.
- Raster counting, when fvh[2]==0:
  - col <= fvh[0] ? COL_START : (!fvh[1] && dv && col<1024) ? col+1 : col.
  - row <= fvh[1] ? ROW_START : (fvh[0] && row<768) ? row+2 : row.
- Qualify: q = !fvh[2] && !fvh[1] && !fvh[0] && dv && (pixel >= THRESH). Uses col/row values before this cycle's update.
- On q: sum_x += col (30 bits), sum_y += row (30 bits), cnt += 1 (20 bits). cnt saturates at 20'hFFFFF; the sums stop with it.
- frame_edge = fvh[2] & ~fvh2_d, where fvh2_d is fvh[2] registered.
- On frame_edge:
  - Sums and cnt are copied into divider operand registers; accumulators clear to 0 in the same cycle.
  - A q in that cycle is impossible because fvh[2]==1.
- FSM:
  - IDLE: on frame_edge go to DIV, bit index=29, busy=1.
  - DIV: restoring division, one quotient bit per cycle, both quotients in parallel (sum_x/cnt, sum_y/cnt). 30 cycles, then go to DONE.
  - If cnt==0, no divide is performed, but DIV still spends 30 cycles.
  - DONE (1 cycle): count<=cnt_latched; found<=(cnt_latched>=MIN_COUNT).
  - DONE, found: cx<=min(qx,X_MAX) and cy<=min(qy,Y_MAX).
  - DONE, not found: cx/cy hold their previous values.
  - DONE outputs: valid=1, busy=0, then return to IDLE.
- Latency: valid is high exactly 31 cycles after the cycle in which frame_edge is high.
- Quotients floor-truncate. qx is 30 bits and is clamped before narrowing to 11 bits; qy likewise to 10 bits.
- frame_edge during DIV: the current division is abandoned, no valid pulse is issued, and the FSM restarts DIV with the new operands.
- frame_edge in the DONE cycle: DONE completes normally, then the FSM enters DIV with the new operands, with no IDLE cycle.
- Outputs are stable between valid pulses.

Test Plan:
- Reset: hold reset=0 mid-stream -> all outputs 0 immediately; asserting reset during DIV -> no valid pulse; next field computes normally.
- 10x10 block at col 100..109, rows 200..218 (even), pixel=FF -> count=100, cx=104, cy=209, found=1, valid 31 cycles after frame_edge.
- Empty field after the above -> count=0, found=0, cx=104, cy=209 held, valid pulses.
- Threshold edge: 20 pixels at FE plus 20 at FF (single column 50, rows 100..138) -> count=20; only the FF pixels counted.
- Clamp: 16-pixel block at col 600..603, row 600..606 -> cx=524, cy=524, found=1.
- Back-to-back: second frame_edge 10 cycles after the first -> no valid for the first field; valid 31 cycles after the second, with the second field's values.
